pci_target: RTL and testbench
=============================

PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h00000000, meaning the first decoded word address.
REQ-002 SHALL have parameter DEPTH, default 10, meaning the number of 32-bit words in target memory (claimed range BASE_ADDR..BASE_ADDR+DEPTH-1).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates occur on posedge clk.
REQ-004 SHALL have port reset  input  1  meaning a synchronous, active-low reset.
REQ-005 SHALL have port iframe  input  1  meaning initiator frame, active-low.
REQ-006 SHALL have port iready  input  1  meaning initiator ready, active-low.
REQ-007 SHALL have port cbe  input  1  meaning command (1=read, 0=write), sampled in the address phase.
REQ-008 SHALL have port addressdata  inout  32  meaning the shared address/data bus, driven only by this block during read data phases and Z otherwise.
REQ-009 SHALL have port deviceSelect  output  1  meaning device select, active-low.
REQ-010 SHALL have port tready  output  1  meaning target ready, active-low.
REQ-011 SHALL have port stop  output  1  meaning target disconnect request, active-low.

Function
REQ-012 SHALL register all outputs and the bus output-enable, with no combinational input-to-output paths.
REQ-013 SHALL implement states IDLE, CLAIM, DATA, STOP, TURN and IGNORE.
REQ-014 In IDLE, at a posedge with iframe==0 (address edge A), SHALL latch addressdata and cbe; on an in-range hit it SHALL set idx=addr-BASE_ADDR and go to CLAIM with deviceSelect low from A+1; on a miss it SHALL go to IGNORE.
REQ-015 IGNORE SHALL keep all outputs high and the bus Z, returning to IDLE at the first posedge with iframe==1 && iready==1.
REQ-016 CLAIM SHALL last exactly one cycle (the bus turnaround cycle, bus Z), then drive tready low from A+2 and enter DATA.
REQ-017 For a read, the block SHALL drive mem[idx] on addressdata from A+2 onward.
REQ-018 A transfer SHALL occur at each posedge in DATA where iready==0 and tready==0.
REQ-019 On each write transfer, mem[idx] SHALL be loaded with addressdata.
REQ-020 On each read transfer, the block SHALL drive mem[idx+1] from the next cycle.
REQ-021 idx SHALL increment by 1 on every transfer.
REQ-022 When iready==1 in DATA (wait state), no transfer SHALL occur; idx, the bus and the outputs SHALL hold.
REQ-023 A transfer with iframe==1 is the final transfer: the block SHALL next drive tready=1 and deviceSelect=1, set the bus to Z, and go to TURN.
REQ-024 A transfer at idx==DEPTH-1 with iframe==0 SHALL cause a disconnect: next cycle tready=1 and stop=0, bus Z, and entry to STOP.
REQ-025 STOP SHALL hold stop=0 and deviceSelect=0 until a posedge with iframe==1, then release both high and go to TURN.
REQ-026 TURN SHALL last one cycle with all outputs high and bus Z, then return to IDLE; an address phase is not accepted during TURN.
REQ-027 If final and end-of-memory coincide (iframe==1 at idx==DEPTH-1), REQ-023 SHALL take priority and stop SHALL stay high.
REQ-028 Address comparison SHALL be unsigned 32-bit; an address below BASE_ADDR or at or above BASE_ADDR+DEPTH SHALL be a miss.
REQ-029 idx SHALL never exceed DEPTH-1, and no wrap-around SHALL occur.
REQ-030 cbe SHALL be ignored outside the address edge.

Reset
REQ-031 At a posedge with reset==0, the block SHALL force deviceSelect=1, tready=1 and stop=1, bus Z, idx=0, state IDLE, and all mem words to 0.
REQ-032 Reset mid-transaction SHALL abort it immediately; words already transferred SHALL NOT be kept, since memory is cleared.
REQ-033 The first address edge SHALL be accepted at the first posedge after reset returns high.

Verification
REQ-034 Bench SHALL cover: write to BASE+2, data 32'hA5A5A5A5, iframe high in the first data phase -> deviceSelect low A+1..A+2, tready low at A+2 only, mem[2]=32'hA5A5A5A5, all high and bus Z at A+3, IDLE at A+4.
REQ-035 Bench SHALL cover: burst write of 1,2,3 to BASE+0, then a 3-word read from BASE+0 -> read data 1,2,3 on consecutive transfer edges from A+2; bus Z during A+1 and after the final transfer.
REQ-036 Bench SHALL cover: read burst with iready high for 2 cycles after the first transfer -> the second word is held on the bus for 3 cycles and idx does not advance during the wait.
REQ-037 Bench SHALL cover: address BASE+10 (miss), and separately BASE-1 -> deviceSelect, tready and stop stay 1 and the bus stays Z throughout, with IDLE after iframe and iready go high.
REQ-038 Bench SHALL cover: read from BASE+8 with iframe held low -> words 8 and 9 transfer, then tready=1 and stop=0 until iframe=1, one TURN cycle follows, then IDLE.
REQ-039 Bench SHALL cover: reset=0 during DATA of a write burst -> next posedge all outputs 1, bus Z, state IDLE, and subsequent reads return 0.

Source files
------------

// File: rtl/pci_target.sv
// Simplified PCI target. It claims DEPTH 32-bit words starting at word address
// BASE_ADDR and services single and burst reads/writes, wait states and disconnect.
module pci_target #(
  parameter logic [31:0] BASE_ADDR = 32'h00000000,
  parameter int          DEPTH     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iframe,
  input  logic        iready,
  input  logic        cbe,
  inout  wire  [31:0] addressdata,
  output logic        deviceSelect,
  output logic        tready,
  output logic        stop
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, CLAIM, DATA, STOP, TURN, IGNORE} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n, idx_inc;
  logic               is_read, is_read_n;
  logic               oe, oe_n;
  logic [31:0]        dout, dout_n;
  logic               dev_sel_nxt, tready_nxt, stop_nxt;
  logic               mem_we;
  logic [31:0]        mem [DEPTH];

  logic [31:0]        offset;
  logic               hit;
  logic               xfer;
  logic               at_last;

  // Offset is taken modulo 2^32, so the lower-bound test must stay separate.
  assign offset  = addressdata - BASE_ADDR;
  assign hit     = (addressdata >= BASE_ADDR) && (offset < 32'(DEPTH));
  assign xfer    = (state == DATA) && !iready && !tready;
  assign at_last = (idx == IDX_W'(DEPTH - 1));
  assign idx_inc = idx + IDX_W'(1);

  assign addressdata = oe ? dout : 32'bz;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    is_read_n   = is_read;
    oe_n        = oe;
    dout_n      = dout;
    dev_sel_nxt = deviceSelect;
    tready_nxt  = tready;
    stop_nxt    = stop;
    mem_we      = 1'b0;

    case (state)
      IDLE: begin
        if (!iframe) begin
          if (hit) begin
            state_n     = CLAIM;
            idx_n       = offset[IDX_W-1:0];
            is_read_n   = cbe;
            dev_sel_nxt = 1'b0;
          end else begin
            state_n = IGNORE;
          end
        end
      end

      IGNORE: begin
        if (iframe && iready) begin
          state_n = IDLE;
        end
      end

      CLAIM: begin
        state_n    = DATA;
        tready_nxt = 1'b0;
        if (is_read) begin
          oe_n   = 1'b1;
          dout_n = mem[idx];
        end
      end

      DATA: begin
        if (xfer) begin
          mem_we = !is_read;
          // Final transfer wins over end-of-memory, so stop stays high then.
          if (iframe) begin
            state_n     = TURN;
            dev_sel_nxt = 1'b1;
            tready_nxt  = 1'b1;
            oe_n        = 1'b0;
            if (!at_last) begin
              idx_n = idx_inc;
            end
          end else if (at_last) begin
            state_n    = STOP;
            tready_nxt = 1'b1;
            stop_nxt   = 1'b0;
            oe_n       = 1'b0;
          end else begin
            idx_n = idx_inc;
            if (is_read) begin
              dout_n = mem[idx_inc];
            end
          end
        end
      end

      STOP: begin
        if (iframe) begin
          state_n     = TURN;
          stop_nxt    = 1'b1;
          dev_sel_nxt = 1'b1;
        end
      end

      TURN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx          <= '0;
      is_read      <= 1'b0;
      oe           <= 1'b0;
      dout         <= '0;
      deviceSelect <= 1'b1;
      tready       <= 1'b1;
      stop         <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      idx          <= idx_n;
      is_read      <= is_read_n;
      oe           <= oe_n;
      dout         <= dout_n;
      deviceSelect <= dev_sel_nxt;
      tready       <= tready_nxt;
      stop         <= stop_nxt;
      if (mem_we) begin
        mem[idx] <= addressdata;
      end
    end
  end

endmodule

// File: tb/tb_pci_target.sv
// Bench for pci_target: per-cycle vector tables for the handshake outputs plus a
// memory model feeding a scoreboard of expected read data.
module tb_pci_target;

  localparam logic [31:0] B     = 32'h0000_0100;
  localparam int          DEPTH = 10;

  logic        clk;
  logic        reset;
  logic        iframe;
  logic        iready;
  logic        cbe;
  logic        ad_oe;
  logic [31:0] ad_drv;
  wire  [31:0] addressdata;
  logic        deviceSelect;
  logic        tready;
  logic        stop;

  // A released bus reads back as all ones through the pullup.
  assign addressdata = ad_oe ? ad_drv : 32'bz;
  pullup bus_pu (addressdata);

  pci_target #(.BASE_ADDR(B), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .iframe       (iframe),
    .iready       (iready),
    .cbe          (cbe),
    .addressdata  (addressdata),
    .deviceSelect (deviceSelect),
    .tready       (tready),
    .stop         (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock edge: inputs for that edge and outputs seen just before it.
  typedef struct {
    logic        rst;
    logic        f;
    logic        r;
    logic        c;
    logic        en;
    logic [31:0] d;
    logic        adr;
    logic        ds;
    logic        trdy;
    logic        stp;
    logic        drv;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  logic [31:0] model [DEPTH];
  int          ptr;
  int          n_checks;
  int          n_fail;

  task automatic add(input logic rst, f, r, c, en, input logic [31:0] d,
                     input logic adr, ds, trdy, stp, drv);
    vec_t v;
    v.rst = rst; v.f = f; v.r = r; v.c = c; v.en = en; v.d = d;
    v.adr = adr; v.ds = ds; v.trdy = trdy; v.stp = stp; v.drv = drv;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset  = v.rst;
    iframe = v.f;
    iready = v.r;
    cbe    = v.c;
    ad_oe  = v.en;
    ad_drv = v.d;
  endtask

  task automatic check_output(input string name, input vec_t v);
    logic [31:0] exp;
    check({name, " deviceSelect"}, 32'(deviceSelect), 32'(v.ds));
    check({name, " tready"}, 32'(tready), 32'(v.trdy));
    check({name, " stop"}, 32'(stop), 32'(v.stp));
    if (v.drv) begin
      exp = sb.pop_front();
      check({name, " read_data"}, addressdata, exp);
    end else if (!v.en) begin
      check({name, " bus_released"}, addressdata, 32'hFFFF_FFFF);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
    end
  endtask

  task automatic run_table(input string tag);
    vec_t v;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply_stimulus(v);
      if (v.adr) begin
        ptr = int'(v.d - B);
      end
      if (v.drv) begin
        sb.push_back((ptr >= 0 && ptr < DEPTH) ? model[ptr] : 32'hDEAD_DEAD);
      end
      #1;
      check_output($sformatf("%s[%0d]", tag, i), v);
      if (!v.rst) begin
        clear_model();
      end else if (!v.r && !v.trdy) begin
        if (!v.drv && v.en && ptr >= 0 && ptr < DEPTH) begin
          model[ptr] = v.d;
        end
        ptr++;
      end
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual still running required finished");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ptr      = 0;
    clear_model();
    reset  = 1'b0;
    iframe = 1'b1;
    iready = 1'b1;
    cbe    = 1'b0;
    ad_oe  = 1'b0;
    ad_drv = '0;
    repeat (2) @(posedge clk);
    #1;

    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("reset_state");

    add(1,0,1,0,1,B+2,1, 1,1,1,0);
    add(1,1,0,1,1,32'hA5A5A5A5,0, 0,1,1,0);
    add(1,1,0,1,1,32'hA5A5A5A5,0, 0,0,1,0);
    add(1,1,1,1,0,0,0, 1,1,1,0);
    add(1,0,1,1,1,B+2,1, 1,1,1,0);
    add(1,1,0,0,0,0,0, 0,1,1,0);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("single_write");

    add(1,0,1,0,1,B+0,1, 1,1,1,0);
    add(1,0,0,1,1,32'd1,0, 0,1,1,0);
    add(1,0,0,1,1,32'd1,0, 0,0,1,0);
    add(1,0,0,1,1,32'd2,0, 0,0,1,0);
    add(1,1,0,1,1,32'd3,0, 0,0,1,0);
    add(1,1,1,1,0,0,0, 1,1,1,0);
    add(1,1,1,1,0,0,0, 1,1,1,0);
    add(1,0,1,1,1,B+0,1, 1,1,1,0);
    add(1,0,0,0,0,0,0, 0,1,1,0);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("burst_wr_rd");

    add(1,0,1,1,1,B+0,1, 1,1,1,0);
    add(1,0,0,0,0,0,0, 0,1,1,0);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,0,1,0,0,0,0, 0,0,1,1);
    add(1,0,1,0,0,0,0, 0,0,1,1);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("wait_read");

    add(1,0,1,1,1,B+10,0, 1,1,1,0);
    add(1,0,0,0,0,0,0, 1,1,1,0);
    add(1,0,0,0,0,0,0, 1,1,1,0);
    add(1,1,0,0,0,0,0, 1,1,1,0);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,0,1,1,1,B+1,1, 1,1,1,0);
    add(1,1,0,0,0,0,0, 0,1,1,0);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,0,1,1,1,B-1,0, 1,1,1,0);
    add(1,1,0,0,0,0,0, 1,1,1,0);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("miss");

    // Write ends exactly on the last word, then a read runs into the end of memory.
    add(1,0,1,0,1,B+8,1, 1,1,1,0);
    add(1,0,0,1,1,32'hCAFE0008,0, 0,1,1,0);
    add(1,0,0,1,1,32'hCAFE0008,0, 0,0,1,0);
    add(1,1,0,1,1,32'hCAFE0009,0, 0,0,1,0);
    add(1,1,1,1,0,0,0, 1,1,1,0);
    add(1,1,1,1,0,0,0, 1,1,1,0);
    add(1,0,1,1,1,B+8,1, 1,1,1,0);
    add(1,0,0,0,0,0,0, 0,1,1,0);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,0,0,0,0,0,0, 0,1,0,0);
    add(1,0,1,0,0,0,0, 0,1,0,0);
    add(1,1,1,0,0,0,0, 0,1,0,0);
    add(1,0,1,1,1,B+0,0, 1,1,1,0);
    add(1,0,1,1,1,B+0,1, 1,1,1,0);
    add(1,1,0,0,0,0,0, 0,1,1,0);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("disconnect");

    add(1,0,1,0,1,B+4,1, 1,1,1,0);
    add(1,0,0,1,1,32'h11111111,0, 0,1,1,0);
    add(1,0,0,1,1,32'h11111111,0, 0,0,1,0);
    add(1,0,0,1,1,32'h22222222,0, 0,0,1,0);
    add(0,0,0,1,1,32'h33333333,0, 0,0,1,0);
    add(1,0,1,1,1,B+4,1, 1,1,1,0);
    add(1,0,0,0,0,0,0, 0,1,1,0);
    add(1,0,0,0,0,0,0, 0,0,1,1);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    add(1,0,1,1,1,B+0,1, 1,1,1,0);
    add(1,1,0,0,0,0,0, 0,1,1,0);
    add(1,1,0,0,0,0,0, 0,0,1,1);
    add(1,1,1,0,0,0,0, 1,1,1,0);
    run_table("reset_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
